// File: rtl/restoring_divider_if.sv
// -----------------------------------------------------------------------------
// restoring_divider_if
//
// Groups the request/result handshake of the restoring divider.
// The clock and reset stay as plain ports on the divider itself.
//
// Parameters
//   WIDTH          operand/result width in bits
//
// Signals
//   i_start        request strobe (requester -> divider)
//   i_dividend     unsigned dividend (requester -> divider)
//   i_divisor      unsigned divisor (requester -> divider)
//   o_busy         divider is working on an accepted request
//   o_done         one-cycle pulse; results are valid in this cycle
//   o_quotient     quotient, held until the next completion
//   o_remainder    remainder, held until the next completion
//   o_div_by_zero  the completed request had a zero divisor
//
// Modports
//   master         the requester; drives i_*, observes o_*
//   slave          the divider; observes i_*, drives o_*
// -----------------------------------------------------------------------------
interface restoring_divider_if #(
  parameter int WIDTH = 4
);

  logic             i_start;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;
  logic             o_div_by_zero;

  modport master (
    output i_start,
    output i_dividend,
    output i_divisor,
    input  o_busy,
    input  o_done,
    input  o_quotient,
    input  o_remainder,
    input  o_div_by_zero
  );

  modport slave (
    input  i_start,
    input  i_dividend,
    input  i_divisor,
    output o_busy,
    output o_done,
    output o_quotient,
    output o_remainder,
    output o_div_by_zero
  );

endinterface : restoring_divider_if

// File: rtl/restoring_divider.sv
// -----------------------------------------------------------------------------
// restoring_divider
//
// Sequential unsigned restoring divider. One quotient bit is produced per
// clock by trial subtraction of the divisor from a shifting partial remainder.
// A request is accepted on a start edge while idle; results appear with a
// one-cycle o_done pulse WIDTH cycles later and are held until the next
// completion.
//
// Parameters
//   WIDTH      operand width, legal range 2..32
//
// Ports
//   i_clk      clock, all state changes on the rising edge
//   i_rst      synchronous active-high reset
//   bus        restoring_divider_if.slave handshake:
//                i_start / i_dividend / i_divisor  request
//                o_busy / o_done                   status
//                o_quotient / o_remainder          results
//                o_div_by_zero                     zero-divisor flag
//
// Build option
//   DIV_ZERO_EARLY_EN  when defined, a zero divisor seen on the start edge
//                      skips the iterations and completes in the next cycle.
//                      When undefined, a zero divisor runs all WIDTH
//                      iterations, which naturally yield quotient = all ones
//                      and remainder = dividend.
// -----------------------------------------------------------------------------
module restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  restoring_divider_if.slave  bus
);

  // Counter just wide enough to hold 0..WIDTH-1 (WIDTH >= 2, so CW >= 1).
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q,   state_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic [WIDTH-1:0] quo_out_q, quo_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dz_q,      dz_d;

  // Working registers. The dividend register doubles as the quotient register:
  // each iteration consumes its MSB and the new quotient bit fills the vacated
  // LSB, so after WIDTH iterations it holds the full quotient.
  logic [WIDTH-1:0] dvd_q,     dvd_d;
  logic [WIDTH-1:0] dvs_q,     dvs_d;
  logic [WIDTH-1:0] rem_q,     rem_d;
  logic [CW-1:0]    cnt_q,     cnt_d;

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  // The partial remainder is WIDTH+1 bits wide while shifting and subtracting.
  // Only the low WIDTH bits are stored: after accept or restore the remainder
  // is always below the divisor, so its top bit is zero.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             accept;
  logic [WIDTH-1:0] rem_iter;
  logic [WIDTH-1:0] quo_iter;
  logic             last_iter;

  assign shifted   = {rem_q, dvd_q[WIDTH-1]};
  assign trial     = shifted - {1'b0, dvs_q};
  // Non-negative trial means the divisor fits: keep the difference.
  assign accept    = ~trial[WIDTH];
  assign rem_iter  = accept ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_iter  = {dvd_q[WIDTH-2:0], accept};
  assign last_iter = (cnt_q == LAST_ITER);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dz_d      = dz_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          dvd_d  = bus.i_dividend;
          dvs_d  = bus.i_divisor;
          rem_d  = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
`ifdef DIV_ZERO_EARLY_EN
          if (bus.i_divisor == '0) begin
            // Same results the full iteration would produce, one cycle later.
            state_d   = ST_DONE;
            done_d    = 1'b1;
            quo_out_d = '1;
            rem_out_d = bus.i_dividend;
            dz_d      = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
`else
          state_d = ST_RUN;
`endif
        end
      end

      ST_RUN: begin
        dvd_d = quo_iter;
        rem_d = rem_iter;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          // Results are published only on the edge that enters DONE.
          state_d   = ST_DONE;
          done_d    = 1'b1;
          quo_out_d = quo_iter;
          rem_out_d = rem_iter;
          dz_d      = (dvs_q == '0);
        end
      end

      ST_DONE: begin
        // A start seen here is deliberately dropped; the requester must retry
        // in the following idle cycle.
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (i_rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dz_q      <= dz_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Working registers
  // ---------------------------------------------------------------------------
  // NOTE: these are deliberately not reset; every one is loaded on the accepted
  // start edge before it is read, and reset already forces IDLE.
  always_ff @(posedge i_clk) begin
    dvd_q <= dvd_d;
    dvs_q <= dvs_d;
    rem_q <= rem_d;
    cnt_q <= cnt_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_quotient    = quo_out_q;
  assign bus.o_remainder   = rem_out_q;
  assign bus.o_div_by_zero = dz_q;

endmodule : restoring_divider

// File: tb/tb_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_restoring_divider
//
// Directed self-checking bench for restoring_divider at WIDTH=4.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_restoring_divider;

  localparam int WIDTH = 4;
  localparam int MAX_WAIT = 40;

`ifdef DIV_ZERO_EARLY_EN
  localparam int DZ_LAT = 0;
`else
  localparam int DZ_LAT = WIDTH;
`endif

  logic clk;
  logic rst;

  int errors = 0;
  int checks = 0;

  restoring_divider_if #(.WIDTH(WIDTH)) bus ();

  restoring_divider #(.WIDTH(WIDTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launch one request from an idle cycle and wait for its done pulse.
  // lat counts cycles after the start edge (0 = cycle right after it);
  // lat = -1 means no done within the bound. Returns in the done cycle.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output int lat, output logic [WIDTH-1:0] q,
                       output logic [WIDTH-1:0] r, output logic dz);
    bus.i_start    = 1'b1;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    @(posedge clk); #1;
    bus.i_start    = 1'b0;
    bus.i_dividend = WIDTH'($urandom);
    bus.i_divisor  = WIDTH'($urandom);
    lat = 0;
    while (bus.o_done !== 1'b1 && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.o_done !== 1'b1) lat = -1;
    q  = bus.o_quotient;
    r  = bus.o_remainder;
    dz = bus.o_div_by_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
    checks++; if (bus.o_quotient !== 4'd0) begin errors++; $display("FAIL reset_q: got %0d want 0", bus.o_quotient); end
    checks++; if (bus.o_remainder !== 4'd0) begin errors++; $display("FAIL reset_r: got %0d want 0", bus.o_remainder); end
    checks++; if (bus.o_div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b want 0", bus.o_div_by_zero); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // 13 / 3 with cycle-by-cycle busy/done tracking.
  task automatic test_basic();
    int n;
    bus.i_start = 1'b1; bus.i_dividend = 4'd13; bus.i_divisor = 4'd3;
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_dividend = 4'd0; bus.i_divisor = 4'd0;
    for (n = 0; n < WIDTH; n++) begin
      checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_run cyc%0d: got %b want 1", n, bus.o_busy); end
      checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL basic_done_early cyc%0d: got %b want 0", n, bus.o_done); end
      @(posedge clk); #1;
    end
    checks++; if (bus.o_done !== 1'b1) begin errors++; $display("FAIL basic_done_at_4: got %b want 1", bus.o_done); end
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_done: got %b want 1", bus.o_busy); end
    checks++; if (bus.o_quotient !== 4'd4) begin errors++; $display("FAIL basic_q: got %0d want 4", bus.o_quotient); end
    checks++; if (bus.o_remainder !== 4'd1) begin errors++; $display("FAIL basic_r: got %0d want 1", bus.o_remainder); end
    checks++; if (bus.o_div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dz: got %b want 0", bus.o_div_by_zero); end
    @(posedge clk); #1;
    checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", bus.o_done); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b want 0", bus.o_busy); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.o_quotient !== 4'd4 || bus.o_remainder !== 4'd1) begin
      errors++; $display("FAIL basic_hold: got q=%0d r=%0d want q=4 r=1", bus.o_quotient, bus.o_remainder);
    end
  endtask

  task automatic test_edges();
    logic [3:0] va [3] = '{4'd15, 4'd0, 4'd15};
    logic [3:0] vb [3] = '{4'd15, 4'd5, 4'd1};
    logic [3:0] eq [3] = '{4'd1,  4'd0, 4'd15};
    logic [3:0] er [3] = '{4'd0,  4'd0, 4'd0};
    int lat;
    logic [3:0] q, r;
    logic dz;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], lat, q, r, dz);
      checks++; if (lat !== WIDTH) begin errors++; $display("FAIL edge%0d_lat: got %0d want %0d", i, lat, WIDTH); end
      checks++; if (q !== eq[i]) begin errors++; $display("FAIL edge%0d_q %0d/%0d: got %0d want %0d", i, va[i], vb[i], q, eq[i]); end
      checks++; if (r !== er[i]) begin errors++; $display("FAIL edge%0d_r %0d/%0d: got %0d want %0d", i, va[i], vb[i], r, er[i]); end
      checks++; if (dz !== 1'b0) begin errors++; $display("FAIL edge%0d_dz: got %b want 0", i, dz); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [3:0] q, r;
    logic dz;
    do_op(4'd7, 4'd0, lat, q, r, dz);
    checks++; if (lat !== DZ_LAT) begin errors++; $display("FAIL dz_lat: got %0d want %0d", lat, DZ_LAT); end
    checks++; if (q !== 4'd15) begin errors++; $display("FAIL dz_q: got %0d want 15", q); end
    checks++; if (r !== 4'd7) begin errors++; $display("FAIL dz_r: got %0d want 7", r); end
    checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", dz); end
    @(posedge clk); #1;
    checks++; if (bus.o_div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag_hold: got %b want 1", bus.o_div_by_zero); end
    // A following nonzero divide must clear the flag.
    do_op(4'd6, 4'd2, lat, q, r, dz);
    checks++; if (dz !== 1'b0 || q !== 4'd3 || r !== 4'd0) begin
      errors++; $display("FAIL dz_clear: got q=%0d r=%0d dz=%b want q=3 r=0 dz=0", q, r, dz);
    end
    @(posedge clk); #1;
  endtask

  // 9/2 with a second start (14/3) two cycles in, then a start in the DONE cycle.
  task automatic test_busy_ignore();
    int n;
    bus.i_start = 1'b1; bus.i_dividend = 4'd9; bus.i_divisor = 4'd2;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_dividend = 4'd14; bus.i_divisor = 4'd3;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    n = 3;
    while (bus.o_done !== 1'b1 && n < MAX_WAIT) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n !== WIDTH) begin errors++; $display("FAIL busy_ign_lat: got %0d want %0d", n, WIDTH); end
    checks++; if (bus.o_quotient !== 4'd4 || bus.o_remainder !== 4'd1) begin
      errors++; $display("FAIL busy_ign_result: got q=%0d r=%0d want q=4 r=1", bus.o_quotient, bus.o_remainder);
    end
    // Start in the DONE cycle must not be accepted.
    bus.i_start = 1'b1; bus.i_dividend = 4'd5; bus.i_divisor = 4'd1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL done_start_ignored: busy got %b want 0", bus.o_busy); end
    repeat (WIDTH + 2) @(posedge clk);
    #1;
    checks++; if (bus.o_quotient !== 4'd4) begin errors++; $display("FAIL done_start_no_result: q got %0d want 4", bus.o_quotient); end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    int lat;
    logic [3:0] q, r;
    logic dz;
    bus.i_start = 1'b1; bus.i_dividend = 4'd11; bus.i_divisor = 4'd4;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      if (bus.o_done === 1'b1) done_seen++;
      @(posedge clk); #1;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", done_seen); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_quotient !== 4'd0 || bus.o_remainder !== 4'd0 || bus.o_div_by_zero !== 1'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got q=%0d r=%0d dz=%b want 0 0 0", bus.o_quotient, bus.o_remainder, bus.o_div_by_zero);
    end
    do_op(4'd11, 4'd4, lat, q, r, dz);
    checks++; if (lat !== WIDTH || q !== 4'd2 || r !== 4'd3 || dz !== 1'b0) begin
      errors++; $display("FAIL rst_mid_fresh: got lat=%0d q=%0d r=%0d dz=%b want lat=%0d q=2 r=3 dz=0", lat, q, r, dz, WIDTH);
    end
    @(posedge clk); #1;
  endtask

  // All 256 operand pairs, each started in the first idle cycle after done.
  task automatic test_back_to_back();
    int lat, exp_lat;
    logic [3:0] q, r, a, b, exp_q, exp_r;
    logic dz, exp_dz;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a = 4'(i);
        b = 4'(j);
        if (j == 0) begin
          exp_q = 4'd15; exp_r = a; exp_dz = 1'b1; exp_lat = DZ_LAT;
        end else begin
          exp_q = 4'(i / j); exp_r = 4'(i % j); exp_dz = 1'b0; exp_lat = WIDTH;
        end
        do_op(a, b, lat, q, r, dz);
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL sweep_lat %0d/%0d: got %0d want %0d", a, b, lat, exp_lat); end
        checks++; if (q !== exp_q) begin errors++; $display("FAIL sweep_q %0d/%0d: got %0d want %0d", a, b, q, exp_q); end
        checks++; if (r !== exp_r) begin errors++; $display("FAIL sweep_r %0d/%0d: got %0d want %0d", a, b, r, exp_r); end
        checks++; if (dz !== exp_dz) begin errors++; $display("FAIL sweep_dz %0d/%0d: got %b want %b", a, b, dz, exp_dz); end
        @(posedge clk); #1;
        checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL sweep_dup_done %0d/%0d: got %b want 0", a, b, bus.o_done); end
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.i_start    = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor  = '0;
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_restoring_divider
